// File: rtl/eth_stream_capture_buffer.sv
// eth_stream_capture_buffer: registered Ethernet-stream tap with an armable
// single-packet capture memory, accessed through the debug-chain register
// handshake (rw_address / read_request / write_request / output_valid).
// Optional build macro: CAPTURE_FILTER_EN adds an SOP data/mask filter at
// registers 5 (value) and 6 (mask).
module eth_stream_capture_buffer #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int DEPTH          = 1024,
  parameter int KEEP_WIDTH     = $clog2(DATAPATH_WIDTH/8),
  parameter int REG_WIDTH      = DATAPATH_WIDTH + 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATAPATH_WIDTH-1:0] i_eths_slave_data,
  input  logic [KEEP_WIDTH-1:0]     i_eths_slave_keep,
  input  logic                      i_eths_slave_valid,
  input  logic                      i_eths_slave_abort,
  input  logic                      i_eths_slave_last,
  output logic [DATAPATH_WIDTH-1:0] o_eths_master_data,
  output logic [KEEP_WIDTH-1:0]     o_eths_master_keep,
  output logic                      o_eths_master_valid,
  output logic                      o_eths_master_abort,
  output logic                      o_eths_master_last,
  input  logic [15:0]               i_rw_address,
  input  logic [REG_WIDTH-1:0]      i_write_data,
  input  logic                      i_read_request,
  input  logic                      i_write_request,
  output logic [REG_WIDTH-1:0]      o_read_data,
  output logic                      o_output_valid
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int ROW_W = DATAPATH_WIDTH + 2 + KEEP_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic             in_pkt;
  logic [31:0]      pkt_cnt;
  logic [15:0]      skip_reg;
  logic [15:0]      skip_rem;
  logic [PTR_W-1:0] wr_ptr;
  logic             truncated;
  logic             aborted;

  logic [ROW_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0] mem_q;

  logic             wait_low;
  logic             mem_pending;
  logic             mem_zero;

  logic             sop;
  logic             sop_qualify;
  logic             full;
  logic             accept;
  logic             wr_fire;
  logic             ctrl_wr;
  logic             is_mem;
  logic [14:0]      mem_idx;
  logic             mem_hit;
  logic             mem_rd_en;
  logic             cap_beat;
  logic [REG_WIDTH-1:0] reg_rdata;
  logic [REG_WIDTH-1:0] row_rdata;

`ifdef CAPTURE_FILTER_EN
  logic [DATAPATH_WIDTH-1:0] filter_value;
  logic [DATAPATH_WIDTH-1:0] filter_mask;
  assign sop_qualify = (o_eths_master_data & filter_mask) == (filter_value & filter_mask);
`else
  assign sop_qualify = 1'b1;
`endif

  assign sop       = o_eths_master_valid && !in_pkt;
  assign full      = (wr_ptr == PTR_W'(DEPTH));
  assign accept    = (i_read_request || i_write_request) && !wait_low && !mem_pending;
  assign wr_fire   = accept && i_write_request;
  assign ctrl_wr   = wr_fire && (i_rw_address == 16'd1);
  assign is_mem    = i_rw_address[15];
  assign mem_idx   = i_rw_address[14:0];
  assign mem_hit   = ((32'(mem_idx) >> AW) == 32'd0) && (32'(mem_idx) < 32'(wr_ptr));
  assign mem_rd_en = accept && !i_write_request && is_mem && mem_hit;
  assign row_rdata = {mem_q[ROW_W-1 -: DATAPATH_WIDTH], mem_q[KEEP_WIDTH+1],
                      mem_q[KEEP_WIDTH], 6'(mem_q[KEEP_WIDTH-1:0])};

  // Memory write strobe: a ctrl write in the same cycle pre-empts the stream.
  always_comb begin
    cap_beat = 1'b0;
    if (!ctrl_wr) begin
      case (state)
        S_ARMED: cap_beat = sop && sop_qualify && (skip_rem == 16'd0);
        S_CAPT:  cap_beat = o_eths_master_valid && !full;
        default: cap_beat = 1'b0;
      endcase
    end
  end

  // Register-map read mux.
  always_comb begin
    reg_rdata = '0;
    case (i_rw_address)
      16'd0: reg_rdata = REG_WIDTH'(pkt_cnt);
      16'd1: reg_rdata = REG_WIDTH'(state != S_IDLE);
      16'd2: reg_rdata = REG_WIDTH'({aborted, truncated, state});
      16'd3: reg_rdata = REG_WIDTH'(wr_ptr);
      16'd4: reg_rdata = REG_WIDTH'(skip_reg);
`ifdef CAPTURE_FILTER_EN
      16'd5: reg_rdata = REG_WIDTH'(filter_value);
      16'd6: reg_rdata = REG_WIDTH'(filter_mask);
`endif
      default: reg_rdata = '0;
    endcase
  end

  // One-cycle registered passthrough of the stream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_eths_master_data  <= '0;
      o_eths_master_keep  <= '0;
      o_eths_master_valid <= 1'b0;
      o_eths_master_abort <= 1'b0;
      o_eths_master_last  <= 1'b0;
    end else begin
      o_eths_master_data  <= i_eths_slave_data;
      o_eths_master_keep  <= i_eths_slave_keep;
      o_eths_master_valid <= i_eths_slave_valid;
      o_eths_master_abort <= i_eths_slave_abort;
      o_eths_master_last  <= i_eths_slave_last;
    end
  end

  // Capture memory: synchronous write and independent synchronous read, no reset.
  always_ff @(posedge i_clk) begin
    if (cap_beat)
      mem[wr_ptr[AW-1:0]] <= {o_eths_master_data, o_eths_master_abort,
                              o_eths_master_last, o_eths_master_keep};
    if (mem_rd_en)
      mem_q <= mem[mem_idx[AW-1:0]];
  end

  // Packet tracking, counter, config registers and capture FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      in_pkt    <= 1'b0;
      pkt_cnt   <= '0;
      skip_reg  <= '0;
      skip_rem  <= '0;
      wr_ptr    <= '0;
      truncated <= 1'b0;
      aborted   <= 1'b0;
`ifdef CAPTURE_FILTER_EN
      filter_value <= '0;
      filter_mask  <= '0;
`endif
    end else begin
      if (o_eths_master_abort)
        in_pkt <= 1'b0;
      else if (o_eths_master_valid)
        in_pkt <= !o_eths_master_last;

      if (o_eths_master_valid && o_eths_master_last && (pkt_cnt != '1))
        pkt_cnt <= pkt_cnt + 32'd1;

      if (wr_fire && (i_rw_address == 16'd4))
        skip_reg <= i_write_data[15:0];
`ifdef CAPTURE_FILTER_EN
      if (wr_fire && (i_rw_address == 16'd5))
        filter_value <= i_write_data[DATAPATH_WIDTH-1:0];
      if (wr_fire && (i_rw_address == 16'd6))
        filter_mask <= i_write_data[DATAPATH_WIDTH-1:0];
`endif

      if (ctrl_wr) begin
        if (!i_write_data[0]) begin
          state <= S_IDLE;
        end else if ((state == S_IDLE) || (state == S_DONE)) begin
          state     <= S_ARMED;
          skip_rem  <= skip_reg;
          wr_ptr    <= '0;
          truncated <= 1'b0;
          aborted   <= 1'b0;
        end
      end else begin
        case (state)
          S_ARMED: begin
            if (sop && sop_qualify) begin
              if (skip_rem != 16'd0) begin
                skip_rem <= skip_rem - 16'd1;
              end else begin
                wr_ptr <= PTR_W'(1);
                if (o_eths_master_last || o_eths_master_abort) begin
                  state   <= S_DONE;
                  aborted <= o_eths_master_abort;
                end else begin
                  state <= S_CAPT;
                end
              end
            end
          end
          S_CAPT: begin
            if (o_eths_master_valid) begin
              if (!full) wr_ptr <= wr_ptr + PTR_W'(1);
              else       truncated <= 1'b1;
            end
            if ((o_eths_master_valid && o_eths_master_last) || o_eths_master_abort) begin
              state   <= S_DONE;
              aborted <= o_eths_master_abort;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Debug handshake: 1-cycle register reads/writes, 2-cycle memory reads,
  // then wait for both request lines to drop before serving again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_output_valid <= 1'b0;
      o_read_data    <= '0;
      wait_low       <= 1'b0;
      mem_pending    <= 1'b0;
      mem_zero       <= 1'b0;
    end else begin
      o_output_valid <= 1'b0;
      if (!i_read_request && !i_write_request)
        wait_low <= 1'b0;
      if (mem_pending) begin
        mem_pending    <= 1'b0;
        o_output_valid <= 1'b1;
        wait_low       <= 1'b1;
        o_read_data    <= mem_zero ? '0 : row_rdata;
      end else if (accept) begin
        if (i_write_request) begin
          o_output_valid <= 1'b1;
          wait_low       <= 1'b1;
        end else if (is_mem) begin
          mem_pending <= 1'b1;
          mem_zero    <= !mem_hit;
        end else begin
          o_read_data    <= reg_rdata;
          o_output_valid <= 1'b1;
          wait_low       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_stream_capture_buffer.sv
// Directed bench for eth_stream_capture_buffer (DEPTH = 16, 32-bit datapath).
module tb_eth_stream_capture_buffer;

  localparam int DW = 32;
  localparam int KW = 2;
  localparam int RW = DW + 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_valid = 1'b0;
  logic          s_abort = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_valid;
  logic          m_abort;
  logic          m_last;
  logic [15:0]   rw_address = '0;
  logic [RW-1:0] write_data = '0;
  logic          read_request = 1'b0;
  logic          write_request = 1'b0;
  logic [RW-1:0] read_data;
  logic          output_valid;

  int total = 0;
  int fails = 0;

  eth_stream_capture_buffer #(.DATAPATH_WIDTH(DW), .DEPTH(16)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_eths_slave_data  (s_data),
    .i_eths_slave_keep  (s_keep),
    .i_eths_slave_valid (s_valid),
    .i_eths_slave_abort (s_abort),
    .i_eths_slave_last  (s_last),
    .o_eths_master_data (m_data),
    .o_eths_master_keep (m_keep),
    .o_eths_master_valid(m_valid),
    .o_eths_master_abort(m_abort),
    .o_eths_master_last (m_last),
    .i_rw_address       (rw_address),
    .i_write_data       (write_data),
    .i_read_request     (read_request),
    .i_write_request    (write_request),
    .o_read_data        (read_data),
    .o_output_valid     (output_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic a);
    s_data = d; s_keep = k; s_last = l; s_abort = a; s_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input string tag, input logic [15:0] a,
                    input logic [RW-1:0] exp, input int exp_lat);
    int lat;
    logic [RW-1:0] d;
    rw_address = a; read_request = 1'b1; lat = 0;
    do begin tick(); lat++; end while (!output_valid && lat < 8);
    d = read_data;
    read_request = 1'b0;
    tick();
    chk(tag, 64'(d), 64'(exp));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [RW-1:0] v);
    int lat;
    rw_address = a; write_data = v; write_request = 1'b1; lat = 0;
    do begin tick(); lat++; end while (!output_valid && lat < 8);
    write_request = 1'b0;
    tick();
    chk({tag, "_ack"}, 64'(lat), 64'd1);
  endtask

  initial begin
    int lat;

    // Reset state
    tick(); tick();
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_mdata", 64'(m_data), 64'd0);
    chk("rst_ovalid", 64'(output_valid), 64'd0);
    chk("rst_rdata", 64'(read_data), 64'd0);
    i_rst = 1'b0;
    tick();

    // Three 4-beat packets with passthrough checks
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        beat(32'hA000_0000 + 32'(p * 16 + b), 2'(b), b == 3, 1'b0);
        chk("pt_data", 64'(m_data), 64'(32'hA000_0000 + 32'(p * 16 + b)));
        chk("pt_keep_last", 64'({m_keep, m_last, m_valid}), 64'({2'(b), b == 3, 1'b1}));
      end
    end
    idle(2);
    rd("pkt_cnt3", 16'd0, 40'd3, 1);
    chk("ovalid_pulse_once", 64'(output_valid), 64'd0);
    rd("status_idle", 16'd2, 40'd0, 1);

    // Arm with skip 0, capture 5-beat packet
    wr("skip0", 16'd4, 40'd0);
    wr("arm1", 16'd1, 40'd1);
    rd("ctrl_armed", 16'd1, 40'd1, 1);
    rd("status_armed", 16'd2, 40'd1, 1);
    for (int b = 0; b < 5; b++)
      beat(32'hC0DE_0000 + 32'(b), (b == 4) ? 2'd1 : 2'd3, b == 4, 1'b0);
    idle(2);
    rd("status_done", 16'd2, 40'd3, 1);
    rd("len5", 16'd3, 40'd5, 1);
    rd("row4", 16'h8004, 40'hC0DE_0004_41, 2);
    rd("row5_zero", 16'h8005, 40'd0, 2);
    rd("row0", 16'h8000, 40'hC0DE_0000_03, 2);
    rd("pkt_cnt4", 16'd0, 40'd4, 1);

    // Arm mid-packet with skip 2: packet A in progress, B and C skipped, D captured
    wr("skip2", 16'd4, 40'd2);
    beat(32'hAAAA_0000, 2'd3, 1'b0, 1'b0);
    beat(32'hAAAA_0001, 2'd3, 1'b0, 1'b0);
    idle(1);
    wr("arm2", 16'd1, 40'd1);
    rd("len_cleared", 16'd3, 40'd0, 1);
    beat(32'hAAAA_0002, 2'd3, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) beat(32'hBBBB_0000 + 32'(b), 2'd3, b == 2, 1'b0);
    for (int b = 0; b < 3; b++) beat(32'hCCCC_0000 + 32'(b), 2'd3, b == 2, 1'b0);
    for (int b = 0; b < 4; b++) beat(32'hDDDD_0000 + 32'(b), 2'd3, b == 3, 1'b0);
    idle(2);
    rd("skip_len4", 16'd3, 40'd4, 1);
    rd("skip_row0", 16'h8000, 40'hDDDD_0000_03, 2);
    rd("skip_row3", 16'h8003, 40'hDDDD_0003_43, 2);
    rd("pkt_cnt8", 16'd0, 40'd8, 1);

    // Truncation: 20-beat packet into a 16-entry buffer
    wr("skip0b", 16'd4, 40'd0);
    wr("arm3", 16'd1, 40'd1);
    for (int b = 0; b < 19; b++) beat(32'hE000_0000 + 32'(b), 2'd3, 1'b0, 1'b0);
    idle(2);
    rd("trunc_still_capt", 16'd2, 40'd6, 1);
    beat(32'hE000_0013, 2'd3, 1'b1, 1'b0);
    idle(2);
    rd("trunc_done", 16'd2, 40'd7, 1);
    rd("trunc_len16", 16'd3, 40'd16, 1);
    rd("trunc_row15", 16'h800F, 40'hE000_000F_03, 2);

    // Abort on third captured beat
    wr("arm4", 16'd1, 40'd1);
    beat(32'hF000_0000, 2'd3, 1'b0, 1'b0);
    beat(32'hF000_0001, 2'd3, 1'b0, 1'b0);
    beat(32'hF000_0002, 2'd3, 1'b0, 1'b1);
    chk("pt_abort", 64'(m_abort), 64'd1);
    idle(2);
    rd("abort_status", 16'd2, 40'd11, 1);
    rd("abort_len3", 16'd3, 40'd3, 1);
    rd("abort_row2", 16'h8002, 40'hF000_0002_83, 2);

    // Disarm keeps captured data; unmapped and out-of-range accesses
    wr("disarm", 16'd1, 40'd0);
    rd("ctrl_idle", 16'd1, 40'd0, 1);
    rd("kept_row0", 16'h8000, 40'hF000_0000_03, 2);
    rd("unmapped_rd", 16'd7, 40'd0, 1);
    wr("unmapped_wr", 16'd9, 40'h12);
    rd("idx_high_bits", 16'h8010, 40'd0, 2);

    // Read and write together: write wins
    rw_address = 16'd4; write_data = 40'd5;
    read_request = 1'b1; write_request = 1'b1; lat = 0;
    do begin tick(); lat++; end while (!output_valid && lat < 8);
    read_request = 1'b0; write_request = 1'b0;
    tick();
    chk("rw_both_ack", 64'(lat), 64'd1);
    rd("rw_both_skip", 16'd4, 40'd5, 1);

    // Asynchronous reset during capture
    wr("skip0c", 16'd4, 40'd0);
    wr("arm5", 16'd1, 40'd1);
    beat(32'h1234_0000, 2'd3, 1'b0, 1'b0);
    beat(32'h1234_0001, 2'd3, 1'b0, 1'b0);
    rd("capt_status", 16'd2, 40'd2, 1);
    s_valid = 1'b1;
    #2 i_rst = 1'b1;
    #1;
    chk("arst_master", 64'({m_valid, m_last, m_abort, m_data}), 64'd0);
    chk("arst_ovalid_rdata", 64'({output_valid, read_data}), 64'd0);
    s_valid = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
    rd("arst_status", 16'd2, 40'd0, 1);
    rd("arst_len", 16'd3, 40'd0, 1);
    rd("arst_cnt", 16'd0, 40'd0, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
